// File: rtl/ext_databus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ext_databus_arbiter_pkg
// Shared definitions for the external databus arbiter:
//   IO_ADDR_W     - default system databus address width
//   ARB_STATES_W  - width of the arbiter state register
//   arb_state_t   - ARB_IDLE (no owner) / ARB_BUSY (one master owns the bus)
//   wrap_inc()    - index increment with explicit modulo-n wrap
// ---------------------------------------------------------------------------
package ext_databus_arbiter_pkg;

   localparam int IO_ADDR_W    = 32;
   localparam int ARB_STATES_W = 2;

   typedef enum logic [ARB_STATES_W-1:0] {
      ARB_IDLE = 2'd0,
      ARB_BUSY = 2'd1
   } arb_state_t;

   // Next index modulo n; the wrap is explicit so non-power-of-two n works.
   function automatic int wrap_inc(input int idx, input int n);
      return ((idx + 32'sd1) >= n) ? 32'sd0 : (idx + 32'sd1);
   endfunction

endpackage

// File: rtl/ext_databus_arbiter_rr_select.sv
// ---------------------------------------------------------------------------
// ext_databus_arbiter_rr_select
// Combinational rotating-priority search. Scans req starting at ptr,
// then ptr+1, ... wrapping at N_MASTERS, and returns the first hit.
// Ports:
//   req  in  N_MASTERS  request vector
//   ptr  in  IDX_W      highest-priority index (must be < N_MASTERS)
//   idx  out IDX_W      first requesting index found (0 when none)
//   any  out 1          at least one request is present
// ---------------------------------------------------------------------------
module ext_databus_arbiter_rr_select
#(
   parameter int N_MASTERS = 4,
   parameter int IDX_W     = 2
)
(
   input  logic [N_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [IDX_W-1:0]     idx,
   output logic                 any
);

   localparam logic [IDX_W:0] L_N = (IDX_W+1)'(N_MASTERS);

   logic [IDX_W:0] w_cand;

   // First-hit search over the rotated request vector.
   always_comb begin
      idx    = {IDX_W{1'b0}};
      any    = 1'b0;
      w_cand = {(IDX_W+1){1'b0}};
      for (int k = 0; k < N_MASTERS; k++) begin
         w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
         // ptr+k is at most 2*N_MASTERS-2, so one subtraction wraps it.
         if (w_cand >= L_N) begin
            w_cand = w_cand - L_N;
         end else begin
            w_cand = w_cand;
         end
         if (!any && req[w_cand[IDX_W-1:0]]) begin
            any = 1'b1;
            idx = w_cand[IDX_W-1:0];
         end else begin
            any = any;
            idx = idx;
         end
      end
   end

endmodule

// File: rtl/ext_databus_arbiter.sv
// ---------------------------------------------------------------------------
// ext_databus_arbiter
// Round-robin arbiter merging N single-beat valid/ready request ports of the
// external address generators onto one system databus. A grant is held for
// at most 2**BURST_W accepted beats, then released with one idle cycle.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   m_valid/m_addr/m_wdata/m_wstrb  per-master request (packed i*W +: W)
//   m_ready            per-master accept (combinational, at most one high)
//   m_rdata            read data broadcast to all masters (= s_rdata)
//   s_valid/s_addr/s_wdata/s_wstrb  system databus request
//   s_ready, s_rdata   system databus accept and read data
//   grant              one-hot current owner, zero when idle
//   busy               high while a master owns the bus
// ---------------------------------------------------------------------------
module ext_databus_arbiter
   import ext_databus_arbiter_pkg::*;
#(
   parameter int N_MASTERS = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = IO_ADDR_W,
   parameter int BURST_W   = 4
)
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_MASTERS-1:0]          m_valid,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
   output logic [N_MASTERS-1:0]          m_ready,
   output logic [DATA_W-1:0]             m_rdata,
   output logic                          s_valid,
   output logic [ADDR_W-1:0]             s_addr,
   output logic [DATA_W-1:0]             s_wdata,
   output logic [DATA_W/8-1:0]           s_wstrb,
   input  logic                          s_ready,
   input  logic [DATA_W-1:0]             s_rdata,
   output logic [N_MASTERS-1:0]          grant,
   output logic                          busy
);

   localparam int IDX_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int STRB_W = DATA_W / 8;

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_gnt_idx;
   logic [IDX_W-1:0]    r_ptr;
   logic [BURST_W-1:0]  r_beat_cnt;

   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_any;
   logic                w_hit;
   logic                w_own_valid;
   logic [ADDR_W-1:0]   w_own_addr;
   logic [DATA_W-1:0]   w_own_wdata;
   logic [STRB_W-1:0]   w_own_wstrb;
   logic                w_accept;
   logic                w_release;

   ext_databus_arbiter_rr_select #(
      .N_MASTERS (N_MASTERS),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .req (m_valid),
      .ptr (r_ptr),
      .idx (w_sel_idx),
      .any (w_any)
   );

   assign m_rdata = s_rdata;

   // AND-OR mux of the owning master's request fields.
   always_comb begin
      w_hit       = 1'b0;
      w_own_valid = 1'b0;
      w_own_addr  = {ADDR_W{1'b0}};
      w_own_wdata = {DATA_W{1'b0}};
      w_own_wstrb = {STRB_W{1'b0}};
      for (int i = 0; i < N_MASTERS; i++) begin
         w_hit       = (r_gnt_idx == IDX_W'(i));
         w_own_valid = w_own_valid | (m_valid[i] & w_hit);
         w_own_addr  = w_own_addr  | (m_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{w_hit}});
         w_own_wdata = w_own_wdata | (m_wdata[i*DATA_W +: DATA_W] & {DATA_W{w_hit}});
         w_own_wstrb = w_own_wstrb | (m_wstrb[i*STRB_W +: STRB_W] & {STRB_W{w_hit}});
      end
   end

   // Next-state and bus outputs.
   always_comb begin
      w_state_nxt = r_state;
      s_valid     = 1'b0;
      s_addr      = {ADDR_W{1'b0}};
      s_wdata     = {DATA_W{1'b0}};
      s_wstrb     = {STRB_W{1'b0}};
      m_ready     = {N_MASTERS{1'b0}};
      grant       = {N_MASTERS{1'b0}};
      busy        = 1'b0;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         ARB_IDLE: begin
            if (w_any) begin
               w_state_nxt = ARB_BUSY;
            end else begin
               w_state_nxt = ARB_IDLE;
            end
         end
         ARB_BUSY: begin
            busy               = 1'b1;
            grant[r_gnt_idx]   = 1'b1;
            s_valid            = w_own_valid;
            s_addr             = w_own_addr;
            s_wdata            = w_own_wdata;
            s_wstrb            = w_own_valid ? w_own_wstrb : {STRB_W{1'b0}};
            m_ready[r_gnt_idx] = s_ready & w_own_valid;
            w_accept           = w_own_valid & s_ready;
            // A pending (valid, not ready) beat can never release, so the
            // grant is frozen for the whole slave stall.
            w_release          = !w_own_valid ||
                                 (w_accept && (r_beat_cnt == {BURST_W{1'b1}}));
            if (w_release) begin
               w_state_nxt = ARB_IDLE;
            end else begin
               w_state_nxt = ARB_BUSY;
            end
         end
         default: begin
            w_state_nxt = ARB_IDLE;
         end
      endcase
   end

   // State, owner, priority pointer and beat counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ARB_IDLE;
         r_gnt_idx  <= {IDX_W{1'b0}};
         r_ptr      <= {IDX_W{1'b0}};
         r_beat_cnt <= {BURST_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ARB_IDLE: begin
               if (w_any) begin
                  r_gnt_idx  <= w_sel_idx;
                  r_beat_cnt <= {BURST_W{1'b0}};
               end
            end
            ARB_BUSY: begin
               if (w_release) begin
                  r_ptr      <= IDX_W'(wrap_inc(int'(r_gnt_idx), N_MASTERS));
                  r_beat_cnt <= {BURST_W{1'b0}};
               end else if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + BURST_W'(1'b1);
               end
            end
            default: begin
               r_beat_cnt <= {BURST_W{1'b0}};
            end
         endcase
      end
   end

endmodule
